div_ctrl: RTL
=============

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port div_req_i  input  1  EX stage holds a valid DIV/DIVU.
REQ-004 SHALL have port div_signed_req_i  input  1  1 = DIV (signed), 0 = DIVU.
REQ-005 SHALL have port op1_i  input  32  dividend from EX.
REQ-006 SHALL have port op2_i  input  32  divisor from EX.
REQ-007 SHALL have port flush_i  input  1  pipeline flush (exception/eret); kills the in-flight divide.
REQ-008 SHALL have port div_ready_i  input  1  divider result-ready flag.
REQ-009 SHALL have port div_result_i  input  64  divider result, {remainder, quotient}.
REQ-010 SHALL have port div_start_o  output  1  divider start; held high until the result is taken.
REQ-011 SHALL have port div_annul_o  output  1  divider cancel.
REQ-012 SHALL have port div_signed_o / div_op1_o / div_op2_o  output  1/32/32  latched operands to the divider.
REQ-013 SHALL have port stall_o  output  1  stall request to the pipeline controller.
REQ-014 SHALL have port hilo_we_o  output  1  HI/LO write enable, one-cycle pulse.
REQ-015 SHALL have ports hi_o / lo_o  output  32/32  remainder / quotient.

Function
REQ-016 SHALL implement the states IDLE, WAIT, DONE and ABORT, all with registered state.
REQ-017 In IDLE with div_req_i=1 and flush_i=0, the block SHALL latch div_signed_req_i, op1_i and op2_i into the div_*_o registers and go to WAIT.
REQ-018 div_start_o SHALL be 1 in every WAIT cycle and 0 in all other states.
REQ-019 div_signed_o, div_op1_o and div_op2_o SHALL stay constant from IDLE exit to DONE exit, because the divider re-reads the operand signs at completion.
REQ-020 In WAIT with div_ready_i=1 and flush_i=0, the block SHALL capture div_result_i[63:32] into hi_o and [31:0] into lo_o, then go to DONE.
REQ-021 In DONE, hilo_we_o SHALL be 1 and div_start_o SHALL be 0 for exactly one cycle, then the block SHALL go to IDLE.
REQ-022 stall_o SHALL be the combinational term (IDLE & div_req_i & ~flush_i) | WAIT | (ABORT & div_req_i).
REQ-023 stall_o SHALL be 0 in DONE so that the divide instruction retires in that cycle.
REQ-024 Latency SHALL be 1 cycle for issue, plus the divider cycles until ready, plus 1 cycle for DONE.
REQ-025 In WAIT with flush_i=1, the block SHALL drive div_annul_o=1 for that cycle, drop start, suppress the capture and go to ABORT; flush wins over a simultaneous div_ready_i.
REQ-026 In DONE with flush_i=1, hilo_we_o SHALL be forced to 0 and hi_o/lo_o SHALL keep their previous values.
REQ-027 ABORT SHALL last exactly 2 cycles, counted by a 2-bit counter, with start=0 so the divider drains from any state back to free; the block SHALL then go to IDLE.
REQ-028 A div_req_i in ABORT SHALL NOT be issued until IDLE.
REQ-029 Back-to-back divides SHALL work: a div_req_i in the cycle after DONE is accepted in IDLE, so start is low for at least one cycle between divides.
REQ-030 A zero divisor SHALL be passed through to the divider, and the block SHALL write hi_o=0 and lo_o=0 when the divider returns its result; no exception SHALL be raised.
REQ-031 flush_i in IDLE SHALL block issue for that cycle.

Reset
REQ-032 While rst=1, the block SHALL set the state to IDLE, the ABORT counter to 0, and all outputs to 0: start, annul, signed, op1, op2, stall (IDLE with no request), hilo_we, hi_o and lo_o.
REQ-033 A rst asserted mid-divide SHALL return the block to IDLE on the next edge with no HI/LO write; the divider SHALL be reset by the same rst.

Verification
REQ-034 The bench SHALL cover: DIV 7/2 -> one hilo_we pulse with hi=0x00000001, lo=0x00000003; stall high from the req cycle until DONE.
REQ-035 The bench SHALL cover: DIV 0xFFFFFFF9/2 (-7/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-036 The bench SHALL cover: DIVU 0xFFFFFFFF/0x10 -> lo=0x0FFFFFFF, hi=0x0000000F; op1_i changed during WAIT does not alter the result.
REQ-037 The bench SHALL cover: DIV x/0 -> hi=0, lo=0, exactly one hilo_we pulse.
REQ-038 The bench SHALL cover: flush_i asserted 10 cycles into WAIT -> annul pulse for 1 cycle, then 2 ABORT cycles, no hilo_we; a following DIV 9/3 -> lo=3, hi=0.
REQ-039 The bench SHALL cover: two back-to-back divides 100/7 then 100/9 -> HI/LO written twice: (2,14) then (1,11); start low for at least 1 cycle between them.

Source files
------------

// File: rtl/div_ctrl.sv
// div_ctrl: sequences a multi-cycle divider for the EX stage.
// It latches the operands and holds start until the divider is ready.
// It then captures {remainder, quotient} and presents a one-cycle HI/LO write.
// A flush annuls the divide in flight, and the divider then gets two drain cycles.
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req_i,
  input  logic        div_signed_req_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        flush_i,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  output logic        stall_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } state_t;

  state_t      state_r;
  logic [1:0]  abort_cnt_r;
  logic        start_r;
  logic        signed_r;
  logic [31:0] op1_r;
  logic [31:0] op2_r;
  // Result staged on divider completion; committed to hi_r/lo_r only when DONE is not flushed
  logic [31:0] res_hi_r;
  logic [31:0] res_lo_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic        in_idle_s;
  logic        in_wait_s;
  logic        in_done_s;
  logic        in_abort_s;

  assign in_idle_s  = (state_r == ST_IDLE);
  assign in_wait_s  = (state_r == ST_WAIT);
  assign in_done_s  = (state_r == ST_DONE);
  assign in_abort_s = (state_r == ST_ABORT);

  // Control FSM: issue, wait for the divider, retire, or drain after a flush
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      abort_cnt_r <= 2'd0;
      start_r     <= 1'b0;
      signed_r    <= 1'b0;
      op1_r       <= 32'd0;
      op2_r       <= 32'd0;
      res_hi_r    <= 32'd0;
      res_lo_r    <= 32'd0;
      hi_r        <= 32'd0;
      lo_r        <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (div_req_i && !flush_i) begin
            signed_r <= div_signed_req_i;
            op1_r    <= op1_i;
            op2_r    <= op2_i;
            start_r  <= 1'b1;
            state_r  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (flush_i) begin
            // Flush beats a simultaneous ready: the result is discarded
            start_r     <= 1'b0;
            abort_cnt_r <= 2'd0;
            state_r     <= ST_ABORT;
          end else if (div_ready_i) begin
            start_r <= 1'b0;
            // The divider's x/0 result is architecturally undefined, so it is forced to zero here
            if (op2_r == 32'd0) begin
              res_hi_r <= 32'd0;
              res_lo_r <= 32'd0;
            end else begin
              res_hi_r <= div_result_i[63:32];
              res_lo_r <= div_result_i[31:0];
            end
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!flush_i) begin
            hi_r <= res_hi_r;
            lo_r <= res_lo_r;
          end
          state_r <= ST_IDLE;
        end
        ST_ABORT: begin
          // Two drain cycles with start low, so the divider can return to free
          if (abort_cnt_r == 2'd1) begin
            abort_cnt_r <= 2'd0;
            state_r     <= ST_IDLE;
          end else begin
            abort_cnt_r <= abort_cnt_r + 2'd1;
          end
        end
        default: begin
          start_r     <= 1'b0;
          abort_cnt_r <= 2'd0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode: stall, annul and the HI/LO write view, all quiet while in reset
  always_comb begin
    stall_o     = 1'b0;
    div_annul_o = 1'b0;
    hilo_we_o   = 1'b0;
    hi_o        = 32'd0;
    lo_o        = 32'd0;
    if (rst) begin
      stall_o     = 1'b0;
      div_annul_o = 1'b0;
      hilo_we_o   = 1'b0;
      hi_o        = 32'd0;
      lo_o        = 32'd0;
    end else begin
      stall_o     = (in_idle_s & div_req_i & ~flush_i) | in_wait_s | (in_abort_s & div_req_i);
      div_annul_o = in_wait_s & flush_i;
      hilo_we_o   = in_done_s & ~flush_i;
      if (in_done_s && !flush_i) begin
        hi_o = res_hi_r;
        lo_o = res_lo_r;
      end else begin
        hi_o = hi_r;
        lo_o = lo_r;
      end
    end
  end

  assign div_start_o  = start_r;
  assign div_signed_o = signed_r;
  assign div_op1_o    = op1_r;
  assign div_op2_o    = op2_r;

endmodule
